// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, default base
// address and the FSM state encoding.
package intr_ctrl_pkg;

    localparam logic [31:0] DEFAULT_BASE = 32'hF000_0100;

    localparam logic [31:0] OFF_STAT = 32'd0;
    localparam logic [31:0] OFF_MASK = 32'd4;
    localparam logic [31:0] OFF_ID   = 32'd8;
    localparam logic [31:0] OFF_EOI  = 32'd12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intrState_e;

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index of the
// lowest set bit (bit 0 has the highest priority).
module prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               any,
    output logic [ID_W-1:0]    idx
);

    assign any = |req;

    // Scanning from the top down lets the lowest set index overwrite the others
    always_comb begin
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: samples device request levels, masks them,
// requests the CPU for the highest-priority source and holds it until EOI.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int              BITS    = 32,
    parameter int              NUM_SRC = 4,
    parameter int              ID_W    = $clog2(NUM_SRC),
    parameter logic [BITS-1:0] BASE    = BITS'(DEFAULT_BASE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic               re,
    input  logic [BITS-1:0]    memAddr,
    input  logic [BITS-1:0]    dataBusIn,
    output logic [BITS-1:0]    dataBusOut,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               int_ack,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id
);

    localparam logic [BITS-1:0] STAT_ADDR = BASE + BITS'(OFF_STAT);
    localparam logic [BITS-1:0] MASK_ADDR = BASE + BITS'(OFF_MASK);
    localparam logic [BITS-1:0] ID_ADDR   = BASE + BITS'(OFF_ID);
    localparam logic [BITS-1:0] EOI_ADDR  = BASE + BITS'(OFF_EOI);

    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] active;
    logic [ID_W-1:0]    curId;
    logic [ID_W-1:0]    winner;
    logic               anyActive;
    logic               maskWr;
    logic               eoiWr;
    logic               rdEn;
    logic               irqReg;
    intrState_e         state;

    assign active = pend & mask;
    assign maskWr = we && (memAddr == MASK_ADDR);
    assign eoiWr  = we && (memAddr == EOI_ADDR);
    assign rdEn   = re && !we;

    prio_enc #(
        .NUM_SRC(NUM_SRC),
        .ID_W   (ID_W)
    ) uPrioEnc (
        .req(active),
        .any(anyActive),
        .idx(winner)
    );

    // Request levels are re-sampled every cycle, so a withdrawn request simply disappears
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            mask <= '0;
        end else begin
            pend <= src_irq;
            if (maskWr) begin
                mask <= dataBusIn[NUM_SRC-1:0];
            end
        end
    end

    // An ack in REQ takes precedence over withdrawal and preemption in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            curId  <= '0;
            irqReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyActive) begin
                        state  <= REQ;
                        curId  <= winner;
                        irqReg <= 1'b1;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state  <= SERVICE;
                        irqReg <= 1'b0;
                    end else if (!anyActive) begin
                        state  <= IDLE;
                        irqReg <= 1'b0;
                    end else begin
                        curId <= winner;
                    end
                end
                SERVICE: begin
                    irqReg <= 1'b0;
                    if (eoiWr) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    irqReg <= 1'b0;
                end
            endcase
        end
    end

    assign irq    = irqReg;
    assign irq_id = curId;

    // Read data must be zero whenever this block is not addressed, since it is OR-ed into the CPU mux
    always_comb begin
        dataBusOut = '0;
        if (rdEn) begin
            case (memAddr)
                STAT_ADDR: dataBusOut[NUM_SRC-1:0] = pend;
                MASK_ADDR: dataBusOut[NUM_SRC-1:0] = mask;
                ID_ADDR: begin
                    dataBusOut[ID_W-1:0] = curId;
                    dataBusOut[BITS-1]   = (state == SERVICE);
                end
                default: dataBusOut = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: a table of per-cycle stimulus/expectation records
// fed through a scoreboard queue, plus a hand-written idle-with-mask-off sequence.
module tb_intr_ctrl;

    localparam logic [31:0] S = 32'hF000_0100;
    localparam logic [31:0] M = 32'hF000_0104;
    localparam logic [31:0] I = 32'hF000_0108;
    localparam logic [31:0] E = 32'hF000_010C;

    typedef struct {
        logic        rst;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  src;
        logic        ack;
        logic        expIrq;
        logic [1:0]  expId;
        logic [31:0] expRd;
    } vecT;

    typedef struct {
        int          tag;
        logic        irq;
        logic [1:0]  id;
        logic [31:0] rd;
    } expT;

    logic        clk;
    logic        reset;
    logic        we;
    logic        re;
    logic [31:0] memAddr;
    logic [31:0] dataBusIn;
    logic [31:0] dataBusOut;
    logic [3:0]  src_irq;
    logic        int_ack;
    logic        irq;
    logic [1:0]  irq_id;

    vecT vecs[$];
    expT expQ[$];
    int  assertCount;
    int  failCount;
    int  stepTag;

    intr_ctrl #(
        .BITS   (32),
        .NUM_SRC(4),
        .ID_W   (2),
        .BASE   (32'hF000_0100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .re        (re),
        .memAddr   (memAddr),
        .dataBusIn (dataBusIn),
        .dataBusOut(dataBusOut),
        .src_irq   (src_irq),
        .int_ack   (int_ack),
        .irq       (irq),
        .irq_id    (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic rst, input logic w, input logic r,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] src, input logic ack,
                          input logic eIrq, input logic [1:0] eId, input logic [31:0] eRd);
        vecT v;
        v.rst = rst; v.we = w; v.re = r; v.addr = addr; v.data = data;
        v.src = src; v.ack = ack; v.expIrq = eIrq; v.expId = eId; v.expRd = eRd;
        vecs.push_back(v);
    endtask

    task automatic checkOutput();
        expT e;
        assertCount++;
        if (expQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard-empty: got no expected entry, required one");
            return;
        end
        e = expQ.pop_front();
        if (irq !== e.irq) begin
            failCount++;
            $display("[TB] FAIL step%0d irq: actual %0b required %0b", e.tag, irq, e.irq);
        end
        assertCount++;
        if (irq_id !== e.id) begin
            failCount++;
            $display("[TB] FAIL step%0d irq_id: actual %0d required %0d", e.tag, irq_id, e.id);
        end
        assertCount++;
        if (dataBusOut !== e.rd) begin
            failCount++;
            $display("[TB] FAIL step%0d dataBusOut: actual %h required %h", e.tag, dataBusOut, e.rd);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, then check just after the next falling edge
    task automatic applyStimulus(input vecT v);
        expT e;
        reset     = v.rst;
        we        = v.we;
        re        = v.re;
        memAddr   = v.addr;
        dataBusIn = v.data;
        src_irq   = v.src;
        int_ack   = v.ack;
        e.tag = stepTag;
        e.irq = v.expIrq;
        e.id  = v.expId;
        e.rd  = v.expRd;
        expQ.push_back(e);
        stepTag++;
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        stepTag     = 0;
        reset = 1'b1; we = 1'b0; re = 1'b0; memAddr = '0; dataBusIn = '0;
        src_irq = '0; int_ack = 1'b0;
        @(negedge clk);

        // Reset state and readback of every register
        addVec(1, 0, 1, M, 0, 4'h0, 0, 0, 0, 32'h0);
        addVec(0, 0, 1, S, 0, 4'h0, 0, 0, 0, 32'h0);
        addVec(0, 0, 1, I, 0, 4'h0, 0, 0, 0, 32'h0);
        foreach (vecs[i]) applyStimulus(vecs[i]);
        vecs.delete();

        // All sources requesting with mask cleared must never raise irq
        for (int n = 0; n < 20; n++) begin
            vecT v;
            v.rst = 0; v.we = 0; v.re = 1; v.addr = S; v.data = 0; v.src = 4'hF; v.ack = 0;
            v.expIrq = 0; v.expId = 0; v.expRd = 32'h0000_000F;
            applyStimulus(v);
        end

        // Single source request, ack, ID readback, EOI and re-request
        addVec(0, 0, 0, S, 0, 4'h0, 0, 0, 0, 32'h0);
        addVec(0, 1, 0, M, 32'hFFFF_FFF4, 4'h0, 0, 0, 0, 32'h0);
        addVec(0, 0, 1, M, 0, 4'h0, 0, 0, 0, 32'h4);
        addVec(0, 0, 0, 0, 0, 4'h4, 0, 0, 0, 32'h0);
        addVec(0, 0, 0, 0, 0, 4'h4, 0, 1, 2, 32'h0);
        addVec(0, 0, 1, I, 0, 4'h4, 1, 0, 2, 32'h8000_0002);
        addVec(0, 0, 1, I, 0, 4'h4, 0, 0, 2, 32'h8000_0002);
        addVec(0, 1, 0, E, 0, 4'h4, 0, 0, 2, 32'h0);
        addVec(0, 0, 0, 0, 0, 4'h4, 0, 1, 2, 32'h0);

        // Preemption by source 0 before ack, then source 2 returns after EOI
        addVec(0, 1, 0, M, 32'h5, 4'h5, 0, 1, 2, 32'h0);
        addVec(0, 0, 0, 0, 0, 4'h5, 0, 1, 0, 32'h0);
        addVec(0, 0, 0, 0, 0, 4'h4, 1, 0, 0, 32'h0);
        addVec(0, 1, 0, E, 0, 4'h4, 0, 0, 0, 32'h0);
        addVec(0, 0, 0, 0, 0, 4'h4, 0, 1, 2, 32'h0);

        // Ack wins over a simultaneous withdrawal; masking in service does not abort
        addVec(0, 0, 0, 0, 0, 4'h0, 1, 0, 2, 32'h0);
        addVec(0, 1, 0, M, 32'h0, 4'h0, 0, 0, 2, 32'h0);
        addVec(0, 0, 1, I, 0, 4'h0, 0, 0, 2, 32'h8000_0002);

        // EOI to idle, stray ack/EOI in idle, EOI and unmapped reads return zero
        addVec(0, 1, 0, E, 0, 4'h0, 0, 0, 2, 32'h0);
        addVec(0, 0, 1, I, 0, 4'h0, 1, 0, 2, 32'h2);
        addVec(0, 1, 0, E, 0, 4'h0, 0, 0, 2, 32'h0);
        addVec(0, 0, 1, E, 0, 4'h0, 0, 0, 2, 32'h0);
        addVec(0, 0, 1, 32'hF000_0110, 0, 4'h0, 0, 0, 2, 32'h0);

        // Masking the requested source while in REQ withdraws the request
        addVec(0, 1, 0, M, 32'h4, 4'h4, 0, 0, 2, 32'h0);
        addVec(0, 0, 1, M, 0, 4'h4, 0, 1, 2, 32'h4);
        addVec(0, 1, 0, M, 32'h0, 4'h4, 0, 1, 2, 32'h0);
        addVec(0, 0, 0, 0, 0, 4'h4, 0, 0, 2, 32'h0);

        // Reset during service, then a write to STAT must not touch MASK
        addVec(0, 1, 0, M, 32'h4, 4'h4, 0, 0, 2, 32'h0);
        addVec(0, 0, 0, 0, 0, 4'h4, 0, 1, 2, 32'h0);
        addVec(0, 0, 1, I, 0, 4'h4, 1, 0, 2, 32'h8000_0002);
        addVec(1, 0, 0, 0, 0, 4'h4, 0, 0, 0, 32'h0);
        addVec(0, 0, 1, I, 0, 4'h0, 0, 0, 0, 32'h0);
        addVec(0, 0, 1, M, 0, 4'h0, 0, 0, 0, 32'h0);
        addVec(0, 1, 0, S, 32'hF, 4'h0, 0, 0, 0, 32'h0);
        addVec(0, 0, 1, M, 0, 4'h0, 0, 0, 0, 32'h0);
        addVec(0, 0, 1, S, 0, 4'h0, 0, 0, 0, 32'h0);
        addVec(0, 1, 1, M, 32'h0, 4'h0, 0, 0, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard-drain: actual %0d leftover entries, required 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
